router_input_port: RTL
======================

# router_input_port

Receive side of the mesh's credit-based flit link: one instance per router input (four mesh directions plus local injection). Accepts 20-bit flits on `in`/`vi` into a small FIFO and computes an XY route from each head flit. It holds that route for the whole packet while presenting flits to the switch allocator. Each flit leaving the FIFO returns one credit pulse on `co` to the upstream transmitter.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥2. The upstream credit counter resets to this value.
- `W`, 20: flit width. Field positions below assume 20.
- `clk` input 1: clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `position` input 4: own node coordinate {x[1:0], y[1:0]}.
- `in` input W: incoming flit.
- `vi` input 1: `in` valid; write on this edge.
- `o` output W: flit at FIFO head.
- `req` output 5: one-hot output-port request. Bit 0 = E (+x), 1 = W (−x), 2 = N (+y), 3 = S (−y), 4 = local.
- `gnt` input 1: allocator accepts `o`; pops the FIFO this edge.
- `co` output 1: credit return, one pulse per flit popped.
- `err` output 1: sticky protocol-error flag.

## Operation
- Flit type is `in[19:18]`:
  - 2'b10 = head
  - 2'b00 = body
  - 2'b01 = tail
  - 2'b11 = single-flit packet (head and tail)
- Destination is carried in head flits only, at [17:14] = {dx, dy}.
- FIFO:
  - Circular, `DEPTH` entries, log2(DEPTH)-bit pointers that wrap.
  - Count register is 0..DEPTH.
  - `o` always shows the entry at the read pointer.
- XY route, computed from the head flit at the FIFO head:
  - dx > x → E; dx < x → W.
  - Otherwise dy > y → N; dy < y → S.
  - Otherwise → local.
- FSM state IDLE (reset state):
  - FIFO non-empty and head entry type is 10 or 11: register the route into `route_q` and go to ACTIVE. `req` stays 0 in this cycle.
  - FIFO non-empty and head entry type is 00 or 01: protocol error. Pop the entry internally, pulse `co`, set `err`, stay in IDLE.
- FSM state ACTIVE:
  - `req = route_q` whenever the FIFO is non-empty, else 0.
  - `gnt` with `req != 0` pops one entry.
  - Popping an entry of type 01 or 11 returns to IDLE next cycle.
  - `gnt` while `req == 0` is ignored.
- Credits:
  - `co` is a register. It is 1 in the cycle after any pop (granted pop or error-drop).
  - Exactly one pulse per popped flit. Back-to-back pops give back-to-back pulses.
- Push:
  - `vi` with count < DEPTH writes the flit.
  - `vi` at count == DEPTH with a pop on the same edge is accepted; count stays DEPTH.
  - `vi` at count == DEPTH without a pop: flit dropped, `err` set, no credit returned.
- Simultaneous push and pop at any count: both happen; count is unchanged.
- `err` clears only on `RST`.

## Timing
- Reset values: FIFO empty, pointers 0, count 0, state IDLE, `route_q` = 0, `req` = 0, `co` = 0, `err` = 0. `o` shows the stale entry 0 and is don't-care while empty.
- Asserting `RST` mid-packet discards all buffered flits immediately. No credits are returned for them; the upstream transmitter is reset by the same `RST`.
- Latency for a head flit arriving at an empty port, `vi` at edge T:
  - T+1: flit visible on `o`, FSM still IDLE.
  - T+2: state ACTIVE and `req` valid.
  - Earliest pop is at edge T+2; `co` is high during cycle T+2..T+3.
- Body flits queued behind a granted head can pop on consecutive edges (one flit per cycle).
- A head flit following a tail pays one IDLE cycle: a one-cycle bubble per packet.
- `req` is never asserted in IDLE. `req` never changes within a packet.

## Test plan
- Single flit: `position` = 4'b0101, send 20'hC_8000 (type 11, dest 4'b0010).
  - `req` = 5'b00010 (W) two cycles after `vi`.
  - With `gnt` held high: one pop, one `co` pulse, FSM back to IDLE.
- 4-flit packet: head type 10 with dest = `position`, then body, body, tail on consecutive cycles, `gnt` = 1 throughout.
  - `req` = 5'b10000 (local) for 4 cycles.
  - 4 consecutive `co` pulses; `o` order matches input order.
- Full and stall: `DEPTH` = 4, `gnt` = 0, send 4 flits.
  - Count = 4, no `co`, `err` = 0.
  - Send a 5th flit without a pop: `err` = 1, and the FIFO still holds the original 4.
- Push-pop at full: count 4, `vi` and `gnt` together on one edge.
  - Count stays 4, exactly one `co` pulse, `err` = 0.
- Headless body flit: in IDLE, send type 00.
  - Entry dropped the next cycle, one `co` pulse, `err` = 1, `req` stays 0.
- Reset mid-packet: `RST` pulse after head plus 1 body are buffered.
  - Outputs go immediately to their reset values: `req` = 0, `co` = 0, `err` = 0, count 0.
  - A new head afterwards routes normally.

Source files
------------

// File: rtl/router_input_port.sv
// Receive side of a credit-based mesh link: flit FIFO, XY route from each head flit,
// per-packet route hold toward the switch allocator, and one credit pulse per popped flit.
module router_input_port #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [3:0]   position,
    input  logic [W-1:0] in,
    input  logic         vi,
    output logic [W-1:0] o,
    output logic [4:0]   req,
    input  logic         gnt,
    output logic         co,
    output logic         err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic [4:0]    route_q;
    logic [4:0]    route;

    logic       empty;
    logic       full;
    logic       head_flit;
    logic       tail_flit;
    logic       pop_gnt;
    logic       pop_err;
    logic       pop;
    logic       push;
    logic       overflow;
    logic [1:0] x, y, dx, dy;

    assign o         = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    // Type 10/11 opens a packet, type 01/11 closes it.
    assign head_flit = o[W-1];
    assign tail_flit = o[W-2];

    assign x  = position[3:2];
    assign y  = position[1:0];
    assign dx = o[W-3:W-4];
    assign dy = o[W-5:W-6];

    always_comb begin
        route = 5'b10000;
        if (dx > x)      route = 5'b00001;
        else if (dx < x) route = 5'b00010;
        else if (dy > y) route = 5'b00100;
        else if (dy < y) route = 5'b01000;
    end

    assign req      = (state == ACTIVE && !empty) ? route_q : 5'b00000;
    assign pop_gnt  = gnt && (req != 5'b00000);
    assign pop_err  = (state == IDLE) && !empty && !head_flit;
    assign pop      = pop_gnt || pop_err;
    // A full FIFO still accepts a flit when a slot frees on the same edge.
    assign push     = vi && (!full || pop);
    assign overflow = vi && full && !pop;

    // NOTE: the storage array has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= IDLE;
            route_q <= '0;
            co      <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            co    <= pop;
            if (pop_err || overflow) err <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty && head_flit) begin
                        state   <= ACTIVE;
                        route_q <= route;
                    end
                end
                ACTIVE: begin
                    if (pop_gnt && tail_flit) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
